// File: rtl/out_chn_fsm.sv
// out_chn_fsm: YakiRouter output channel; pops routed packets from the port FIFO and re-serialises them.
// Define OUT_CHN_PARITY_EN to append a trailing XOR parity byte to every packet.
module out_chn_fsm #(
    parameter int data_size       = 8,
    parameter int pkt_length_bits = 5,
    parameter int pkt_addr_bits   = data_size - pkt_length_bits,
    parameter int port_addr       = 0
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_ch_en,
    input  logic                 i_fifo_empty,
    input  logic [data_size-1:0] i_fifo_data,
    output logic                 o_fifo_rd_en,
    input  logic                 i_ready,
    output logic                 o_valid,
    output logic [data_size-1:0] o_data_out,
    input  logic                 i_clr_errors,
    output logic                 o_error,
    output logic                 o_busy,
    output logic                 o_pkt_done
);
`ifdef OUT_CHN_PARITY_EN
    typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY, DROP} state_t;
    logic [data_size-1:0] acc_q, acc_d;
`else
    typedef enum logic [1:0] {IDLE, PAYLOAD, DROP} state_t;
`endif
    localparam logic [pkt_length_bits-1:0] ONE = pkt_length_bits'(1);
    state_t state_q, state_d;
    logic [pkt_length_bits-1:0] cnt_q, cnt_d;
    logic [data_size-1:0] data_q, data_d, load_data;
    logic valid_q, valid_d, last_q, last_d, err_q, err_d, done_q, done_d;
    logic slot_free, hdr_zero, hdr_ok, load, load_last, err_set;
    logic [pkt_addr_bits-1:0] hdr_addr;
    logic [pkt_length_bits-1:0] hdr_len;

    assign hdr_addr  = i_fifo_data[data_size-1:pkt_length_bits];
    assign hdr_len   = i_fifo_data[pkt_length_bits-1:0];
    assign hdr_zero  = hdr_len == '0;
    assign hdr_ok    = hdr_addr == pkt_addr_bits'(port_addr) && !hdr_zero;
    assign slot_free = !valid_q || i_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        o_fifo_rd_en = 1'b0;
        load         = 1'b0;
        load_last    = 1'b0;
        load_data    = i_fifo_data;
        err_set      = 1'b0;
`ifdef OUT_CHN_PARITY_EN
        acc_d        = acc_q;
`endif
        case (state_q)
            IDLE: if (i_ch_en && !i_fifo_empty) begin
                if (hdr_zero) begin
                    o_fifo_rd_en = 1'b1;
                    err_set      = 1'b1;
                end else if (!hdr_ok) begin
                    o_fifo_rd_en = 1'b1;
                    err_set      = 1'b1;
                    cnt_d        = hdr_len;
                    state_d      = DROP;
                end else if (slot_free) begin
                    o_fifo_rd_en = 1'b1;
                    load         = 1'b1;
                    cnt_d        = hdr_len;
                    state_d      = PAYLOAD;
`ifdef OUT_CHN_PARITY_EN
                    acc_d        = i_fifo_data;
`endif
                end
            end
            PAYLOAD: if (slot_free && !i_fifo_empty) begin
                o_fifo_rd_en = 1'b1;
                load         = 1'b1;
                cnt_d        = cnt_q - ONE;
`ifdef OUT_CHN_PARITY_EN
                acc_d        = acc_q ^ i_fifo_data;
                state_d      = cnt_q == ONE ? PARITY : PAYLOAD;
`else
                load_last    = cnt_q == ONE;
                state_d      = cnt_q == ONE ? IDLE : PAYLOAD;
`endif
            end
`ifdef OUT_CHN_PARITY_EN
            PARITY: if (slot_free) begin
                load      = 1'b1;
                load_last = 1'b1;
                load_data = acc_q;
                state_d   = IDLE;
            end
`endif
            DROP: if (!i_fifo_empty) begin
                o_fifo_rd_en = 1'b1;
                cnt_d        = cnt_q - ONE;
                state_d      = cnt_q == ONE ? IDLE : DROP;
            end
            default: state_d = IDLE;
        endcase
        // the output register only changes when its slot is free, so a stalled byte stays put
        valid_d = load || (valid_q && !i_ready);
        data_d  = load ? load_data : data_q;
        last_d  = load ? load_last : last_q;
        err_d   = err_set || (err_q && !i_clr_errors);
        done_d  = valid_q && i_ready && last_q;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef OUT_CHN_PARITY_EN
            acc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
            done_q  <= done_d;
`ifdef OUT_CHN_PARITY_EN
            acc_q   <= acc_d;
`endif
        end
    end

    assign o_valid    = valid_q;
    assign o_data_out = data_q;
    assign o_error    = err_q;
    assign o_pkt_done = done_q;
    assign o_busy     = state_q != IDLE || valid_q;
endmodule

// File: tb/tb_out_chn_fsm.sv
// tb_out_chn_fsm: scoreboard bench for out_chn_fsm with port_addr 2; the bench models the port FIFO.
// Expected bytes are derived per packet from the header rules and popped by an independent monitor.
module tb_out_chn_fsm;
    typedef struct {
        logic [7:0] data;
        bit         last;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0;
    logic ch_en = 1'b0, fifo_empty = 1'b1, rd_en, ready = 1'b0, valid, clr_err = 1'b0;
    logic error, busy, pkt_done;
    logic [7:0] fifo_data = 8'h00, data_out;

    logic [7:0] fq[$];
    logic [7:0] src[$];
    exp_t exp_q[$];
    int checks = 0, errors = 0, npops = 0, nbad = 0;
    bit pop = 1'b0;

    out_chn_fsm #(.data_size(8), .pkt_length_bits(5), .port_addr(2)) dut (
        .i_clk(clk), .i_rstn(rst_n), .i_ch_en(ch_en), .i_fifo_empty(fifo_empty),
        .i_fifo_data(fifo_data), .o_fifo_rd_en(rd_en), .i_ready(ready), .o_valid(valid),
        .o_data_out(data_out), .i_clr_errors(clr_err), .o_error(error), .o_busy(busy),
        .o_pkt_done(pkt_done)
    );

    always #5 clk = ~clk;

    function automatic void check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    // Queue a packet; legal ones contribute header, payload and (optionally) parity to the scoreboard.
    task automatic add_pkt(input logic [2:0] a, input logic [4:0] l, input bit fixed, input bit direct);
        logic [7:0] b, x;
        bit legal;
        legal = a == 3'd2 && l != 5'd0;
        b = {a, l};
        x = b;
        if (!legal) nbad++;
        for (int i = 0; i <= ((legal || a == 3'd2 || l == 5'd0) && !(a != 3'd2 && l != 5'd0) ? (legal ? int'(l) : 0) : int'(l)); i++) begin
            if (i > 0) b = fixed ? 8'(8'h11 * i) : 8'($urandom);
            if (i > 0) x = x ^ b;
            if (direct) fq.push_back(b);
            else src.push_back(b);
`ifdef OUT_CHN_PARITY_EN
            if (legal) exp_q.push_back('{b, 1'b0});
`else
            if (legal) exp_q.push_back('{b, i == int'(l)});
`endif
        end
`ifdef OUT_CHN_PARITY_EN
        if (legal) exp_q.push_back('{x, 1'b1});
`endif
    endtask

    task automatic step(input bit rdy, input bit en, input bit clr, input bit feed);
        @(posedge clk);
        #1;
        if (pop) void'(fq.pop_front());
        if (feed && src.size() > 0) fq.push_back(src.pop_front());
        ready = rdy;
        ch_en = en;
        clr_err = clr;
        fifo_empty = fq.size() == 0;
        fifo_data = fq.size() > 0 ? fq[0] : 8'h00;
        #1;
        pop = rd_en;
        if (pop) begin
            npops++;
            check(!fifo_empty, "pop_when_empty", 1, 0);
        end
    endtask

    logic [7:0] pd = 8'h00;
    bit pv = 1'b0, pr = 1'b0, done_exp = 1'b0;
    exp_t e;
    always @(negedge clk) if (rst_n) begin
        check(pkt_done == done_exp, "pkt_done", int'(pkt_done), int'(done_exp));
        if (pv && !pr) check(valid && data_out == pd, "stall_hold", int'(data_out), int'(pd));
        done_exp = 1'b0;
        if (valid && ready) begin
            if (exp_q.size() == 0) check(1'b0, "unexpected_byte", int'(data_out), 0);
            else begin
                e = exp_q.pop_front();
                check(data_out == e.data, "data_out", int'(data_out), int'(e.data));
                done_exp = e.last;
            end
        end
        pv = valid;
        pr = ready;
        pd = data_out;
    end

    initial begin
        int n, p0;
        repeat (3) @(posedge clk);
        #1;
        check(valid == 1'b0, "rst_valid", int'(valid), 0);
        check(data_out == 8'h00, "rst_data", int'(data_out), 0);
        check(error == 1'b0, "rst_error", int'(error), 0);
        check(busy == 1'b0, "rst_busy", int'(busy), 0);
        check(pkt_done == 1'b0, "rst_done", int'(pkt_done), 0);
        check(rd_en == 1'b0, "rst_rd_en", int'(rd_en), 0);
        @(negedge clk) rst_n = 1'b1;
        // channel disabled with a packet waiting: nothing may move
        add_pkt(3'd2, 5'd3, 1'b1, 1'b1);
        repeat (6) step(1'b1, 1'b0, 1'b0, 1'b0);
        check(npops == 0, "disabled_pops", npops, 0);
        check(busy == 1'b0, "disabled_busy", int'(busy), 0);
        n = 0;
        while ((exp_q.size() > 0 || busy) && n < 500) begin
            step($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, 1'b0, 1'b0);
            n++;
        end
        check(exp_q.size() == 0, "first_pkt_drained", exp_q.size(), 0);
        check(error == 1'b0, "legal_no_error", int'(error), 0);
        // zero-length header: single pop, error, no output
        p0 = npops;
        add_pkt(3'd2, 5'd0, 1'b0, 1'b1);
        repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0);
        check(npops - p0 == 1, "len0_pops", npops - p0, 1);
        check(error == 1'b1, "len0_error", int'(error), 1);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        check(error == 1'b0, "clr_error", int'(error), 0);
        // address mismatch: header plus two payload bytes dropped silently
        p0 = npops;
        add_pkt(3'd3, 5'd2, 1'b0, 1'b1);
        repeat (6) step(1'b1, 1'b1, 1'b0, 1'b0);
        check(npops - p0 == 3, "drop_pops", npops - p0, 3);
        check(error == 1'b1, "drop_error", int'(error), 1);
        // random mix with stalls, FIFO underflow and enable toggling
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 5))
                0: add_pkt(3'd2, 5'd0, 1'b0, 1'b0);
                1: add_pkt(3'(2 + $urandom_range(1, 7)), 5'($urandom_range(1, 6)), 1'b0, 1'b0);
                default: add_pkt(3'd2, 5'($urandom_range(1, 8)), 1'b0, 1'b0);
            endcase
        end
        n = 0;
        while ((src.size() > 0 || fq.size() > 0 || exp_q.size() > 0 || busy) && n < 20000) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 1'b0, $urandom_range(0, 3) != 0);
            n++;
        end
        check(n < 20000, "random_timeout", n, 20000);
        check(exp_q.size() == 0, "random_drained", exp_q.size(), 0);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        check(error == 1'b1, "random_error_sticky", int'(error), 1);
        check(busy == 1'b0, "final_busy", int'(busy), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/out_chn_fsm.md
# out_chn_fsm

Output-channel state machine for the YakiRouter. It is the transmit-side counterpart of the input-channel FSM: it pops a routed packet from its port FIFO and re-serialises it byte by byte onto the output port under a valid/ready handshake. It checks each header against its own port address and length rules, drops illegal packets, and raises a sticky error. One instance sits between each output FIFO and its router output pin group.

## Interface
- `data_size`, default 8: byte width of FIFO and output data.
- `pkt_length_bits`, default 5: header LSB field holding payload length.
- `pkt_addr_bits`, default `data_size-pkt_length_bits` (3): header MSB field holding destination address.
- `port_addr`, default 0: this channel's address; headers must match it.

- `i_clk`, in, 1: clock, rising edge.
- `i_rstn`, in, 1: asynchronous active-low reset.
- `i_ch_en`, in, 1: permits starting a new packet.
- `i_fifo_empty`, in, 1: port FIFO empty.
- `i_fifo_data`, in, `data_size`: FIFO head word (show-ahead, valid when not empty).
- `o_fifo_rd_en`, out, 1: pop FIFO head this cycle.
- `i_ready`, in, 1: downstream accepts `o_data_out` this cycle.
- `o_valid`, out, 1: `o_data_out` holds a byte.
- `o_data_out`, out, `data_size`: transmitted byte.
- `i_clr_errors`, in, 1: clears `o_error`.
- `o_error`, out, 1: sticky error flag.
- `o_busy`, out, 1: packet in flight.
- `o_pkt_done`, out, 1: one-cycle pulse on acceptance of a packet's last byte.

## Operation
- Header format: addr = `hdr[data_size-1:pkt_length_bits]`, len = `hdr[pkt_length_bits-1:0]`. len = payload bytes after the header. Legal len is 1..31.
- Output register slot is free when `!o_valid || i_ready`. A pop occurs only when the slot is free, `!i_fifo_empty`, and the state needs a FIFO byte. `o_fifo_rd_en` is combinational on these conditions. DROP pops without needing a free slot.
- States:
  - IDLE: if `i_ch_en && !i_fifo_empty`, inspect the head.
    - Legal header (addr == `port_addr`, len != 0) and slot free: pop it, load the output register, load the counter with len, set parity accumulator = header, go to PAYLOAD.
    - addr mismatch: pop it, set error, counter = len, go to DROP.
    - len == 0: pop it, set error, stay in IDLE.
  - PAYLOAD: each pop loads the output register, decrements the counter, and XORs the byte into the accumulator. On the pop with counter == 1, go to PARITY (macro defined) or IDLE.
  - PARITY: when the slot is free, load the accumulator into the output register (no pop) and go to IDLE.
  - DROP: pop one byte per cycle while the FIFO is non-empty, with no output. Counter reaching 0 returns to IDLE.
- FIFO empty mid-packet: stall with no pop and no counter change. `o_valid` drops once the held byte is accepted (bubble). There is no timeout.
- `i_ch_en` low only blocks leaving IDLE. A packet in progress always completes.
- `o_data_out` is stable while `o_valid && !i_ready`.
- `o_error` is set on a mismatch or len 0, cleared by `i_clr_errors`. A set and a clear in the same cycle leave it set. An error never halts the channel.
- `o_busy` = (state != IDLE) || `o_valid`.

## Timing
- Reset: state IDLE, counter 0, accumulator 0, `o_valid`=0, `o_data_out`=0, `o_error`=0, `o_pkt_done`=0, `o_busy`=0. `o_fifo_rd_en`=0 because the state is IDLE and no pop condition holds.
- Pop in cycle N puts the byte on `o_data_out` with `o_valid`=1 in cycle N+1.
- Throughput is 1 byte/cycle with `i_ready` held high. Back-to-back packets need no idle cycle: IDLE is re-entered and the next header popped when the slot frees.
- A packet of len L occupies L+1 output beats, or L+2 with parity.
- `o_pkt_done` is registered and asserts the cycle after the last byte's `o_valid && i_ready`.
- Asynchronous reset mid-packet aborts it immediately. Unsent FIFO bytes remain and are treated as the next header.

## Configuration
- `OUT_CHN_PARITY_EN` defined: PARITY state is present and one trailing byte is emitted, equal to the XOR of the header and all payload bytes.
- Undefined: no PARITY state and no accumulator. The last payload byte is the packet's last byte.

## Test plan
- Legal packet, `port_addr`=2: FIFO holds 0x43 (addr 2, len 3), then 0x11, 0x22, 0x33, `i_ready`=1.
  - Output 0x43, 0x11, 0x22, 0x33, plus parity 0x43^0x11^0x22^0x33 = 0x43 with `OUT_CHN_PARITY_EN`.
  - `o_pkt_done` pulses once and `o_error` stays 0.
- Backpressure: same packet with `i_ready` low 3 cycles on the second beat. 0x11 is held stable, no pops occur during the stall, and all bytes arrive in order.
- Address mismatch: header 0x62 (addr 3, len 2), then 0xAA, 0xBB, then a legal packet. Three pops with no `o_valid`, `o_error`=1, and the legal packet is then transmitted intact.
- len 0: header 0x40. One pop, `o_error`=1, no output. Pulsing `i_clr_errors` clears `o_error` the next cycle.
- FIFO underflow: only the header and the first payload byte are present, and the rest arrive 5 cycles later. Bubbles appear on `o_valid`, the counter is unaffected, and the output is a complete packet.
- `i_ch_en`=0 with a packet queued: no pop and `o_busy`=0. Deasserting `i_ch_en` mid-packet still lets that packet complete.
